// File: rtl/rf_write_scheduler_pkg.sv
// rtl/rf_write_scheduler_pkg.sv - shared widths, state encodings and commit entry type
package rf_write_scheduler_pkg;

    localparam int REG_ADDR_BUS   = 5;
    localparam int DATA_BUS       = 32;
    localparam int ROB_ADDR_WIDTH = 5;
    localparam int ROB_ADDR_BUS   = ROB_ADDR_WIDTH;
    localparam int NUM_REGS       = 1 << REG_ADDR_BUS;

    localparam logic [1:0] ST_NORMAL  = 2'd0;
    localparam logic [1:0] ST_FIXUP   = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;
    localparam logic [1:0] ST_RESTORE = 2'd3;

    typedef struct packed {
        logic [REG_ADDR_BUS-1:0] addr;
        logic [ROB_ADDR_BUS-1:0] tag;
        logic [DATA_BUS-1:0]     data;
    } commit_entry_t;

    function automatic logic [DATA_BUS-1:0] tag_to_data(input logic [ROB_ADDR_BUS-1:0] tag);
        return {{(DATA_BUS-ROB_ADDR_BUS){1'b0}}, tag};
    endfunction

endpackage

// File: rtl/rf_write_scheduler_commit_fifo.sv
// rtl/rf_write_scheduler_commit_fifo.sv - synchronous FIFO buffering retired register writes
module rf_write_scheduler_commit_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      push_i,
    input  logic [WIDTH-1:0]          push_data_i,
    input  logic                      pop_i,
    output logic                      full_o,
    output logic                      empty_o,
    output logic [$clog2(DEPTH):0]    count_o,
    output logic [WIDTH-1:0]          head_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB distinguishes full from empty when the low bits match.
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
            if (do_pop)  rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end

endmodule

// File: rtl/rf_write_scheduler.sv
// rtl/rf_write_scheduler.sv - arbitrates the register file write channel between rename and commit
module rf_write_scheduler
    import rf_write_scheduler_pkg::*;
#(
    parameter int COMMIT_FIFO_DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     rename_valid_i,
    output logic                     rename_ready_o,
    input  logic [REG_ADDR_BUS-1:0]  rename_addr_i,
    input  logic [ROB_ADDR_BUS-1:0]  rename_tag_i,
    input  logic                     commit_valid_i,
    output logic                     commit_ready_o,
    input  logic [REG_ADDR_BUS-1:0]  commit_addr_i,
    input  logic [ROB_ADDR_BUS-1:0]  commit_tag_i,
    input  logic [DATA_BUS-1:0]      commit_data_i,
    input  logic                     flush_req_i,
    output logic                     flush_done_o,
    output logic                     rf_read_hold_o,
    output logic                     rf_write_en_o,
    output logic                     rf_write_restore_o,
    output logic                     rf_write_is_ref_o,
    output logic [REG_ADDR_BUS-1:0]  rf_write_addr_o,
    output logic [DATA_BUS-1:0]      rf_write_data_o
);

    localparam int CNT_W = $clog2(COMMIT_FIFO_DEPTH) + 1;

    logic [1:0]              state_q, state_d;
    logic [NUM_REGS-1:0]     shadow_valid_q;
    logic [ROB_ADDR_BUS-1:0] shadow_tag_q [NUM_REGS];

    commit_entry_t           push_entry;
    commit_entry_t           head;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [CNT_W-1:0]        fifo_count;
    logic                    fifo_push;
    logic                    fifo_pop;

    logic                    do_head;
    logic                    shadow_set;
    logic                    shadow_clr;
    logic                    shadow_clr_all;

    assign push_entry = '{addr: commit_addr_i, tag: commit_tag_i, data: commit_data_i};
    assign fifo_push  = commit_valid_i && commit_ready_o;

    rf_write_scheduler_commit_fifo #(
        .DEPTH (COMMIT_FIFO_DEPTH),
        .WIDTH ($bits(commit_entry_t))
    ) u_commit_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (fifo_push),
        .push_data_i (push_entry),
        .pop_i       (fifo_pop),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count),
        .head_o      (head)
    );

    always_comb begin
        state_d            = state_q;
        rename_ready_o     = 1'b0;
        commit_ready_o     = 1'b0;
        flush_done_o       = 1'b0;
        rf_read_hold_o     = 1'b0;
        rf_write_en_o      = 1'b0;
        rf_write_restore_o = 1'b0;
        rf_write_is_ref_o  = 1'b0;
        rf_write_addr_o    = '0;
        rf_write_data_o    = '0;
        fifo_pop           = 1'b0;
        do_head            = 1'b0;
        shadow_set         = 1'b0;
        shadow_clr         = 1'b0;
        shadow_clr_all     = 1'b0;

        if (!rst_i) begin
            case (state_q)
                ST_NORMAL: begin
                    commit_ready_o = !fifo_full && !flush_req_i;
                    rename_ready_o = !fifo_full && !flush_req_i;
                    if (flush_req_i) begin
                        state_d = fifo_empty ? ST_RESTORE : ST_DRAIN;
                    end else if (fifo_full) begin
                        do_head = 1'b1;
                    end else if (rename_valid_i) begin
                        if (rename_addr_i != '0) begin
                            rf_write_en_o     = 1'b1;
                            rf_write_is_ref_o = 1'b1;
                            rf_write_addr_o   = rename_addr_i;
                            rf_write_data_o   = tag_to_data(rename_tag_i);
                            shadow_set        = 1'b1;
                        end
                    end else if (!fifo_empty) begin
                        do_head = 1'b1;
                    end

                    if (do_head) begin
                        if (head.addr == '0) begin
                            fifo_pop = 1'b1;
                        end else begin
                            rf_write_en_o   = 1'b1;
                            rf_write_addr_o = head.addr;
                            rf_write_data_o = head.data;
                            // A newer rename owns this register: write the value, then re-point it.
                            if (shadow_valid_q[head.addr] && shadow_tag_q[head.addr] != head.tag) begin
                                rf_read_hold_o = 1'b1;
                                rename_ready_o = 1'b0;
                                state_d        = ST_FIXUP;
                            end else begin
                                fifo_pop   = 1'b1;
                                shadow_clr = 1'b1;
                            end
                        end
                    end
                end
                ST_FIXUP: begin
                    rf_write_en_o     = 1'b1;
                    rf_write_is_ref_o = 1'b1;
                    rf_write_addr_o   = head.addr;
                    rf_write_data_o   = tag_to_data(shadow_tag_q[head.addr]);
                    fifo_pop          = 1'b1;
                    state_d           = ST_NORMAL;
                end
                ST_DRAIN: begin
                    fifo_pop = 1'b1;
                    if (head.addr != '0) begin
                        rf_write_en_o   = 1'b1;
                        rf_write_addr_o = head.addr;
                        rf_write_data_o = head.data;
                    end
                    if (fifo_count == CNT_W'(1)) state_d = ST_RESTORE;
                end
                default: begin
                    rf_write_restore_o = 1'b1;
                    flush_done_o       = 1'b1;
                    shadow_clr_all     = 1'b1;
                    state_d            = ST_NORMAL;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= ST_NORMAL;
            shadow_valid_q <= '0;
        end else begin
            state_q <= state_d;
            if (shadow_clr_all) begin
                shadow_valid_q <= '0;
            end else begin
                if (shadow_set) shadow_valid_q[rename_addr_i] <= 1'b1;
                if (shadow_clr) shadow_valid_q[head.addr] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (shadow_set) shadow_tag_q[rename_addr_i] <= rename_tag_i;
    end

endmodule

// File: tb/tb_rf_write_scheduler.sv
// tb/tb_rf_write_scheduler.sv - directed self-checking bench for rf_write_scheduler
module tb_rf_write_scheduler;

    logic        clk;
    logic        rst;
    logic        rename_valid;
    logic        rename_ready;
    logic [4:0]  rename_addr;
    logic [4:0]  rename_tag;
    logic        commit_valid;
    logic        commit_ready;
    logic [4:0]  commit_addr;
    logic [4:0]  commit_tag;
    logic [31:0] commit_data;
    logic        flush_req;
    logic        flush_done;
    logic        rf_read_hold;
    logic        rf_write_en;
    logic        rf_write_restore;
    logic        rf_write_is_ref;
    logic [4:0]  rf_write_addr;
    logic [31:0] rf_write_data;

    int n_total;
    int n_pass;

    rf_write_scheduler #(.COMMIT_FIFO_DEPTH(4)) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .rename_valid_i     (rename_valid),
        .rename_ready_o     (rename_ready),
        .rename_addr_i      (rename_addr),
        .rename_tag_i       (rename_tag),
        .commit_valid_i     (commit_valid),
        .commit_ready_o     (commit_ready),
        .commit_addr_i      (commit_addr),
        .commit_tag_i       (commit_tag),
        .commit_data_i      (commit_data),
        .flush_req_i        (flush_req),
        .flush_done_o       (flush_done),
        .rf_read_hold_o     (rf_read_hold),
        .rf_write_en_o      (rf_write_en),
        .rf_write_restore_o (rf_write_restore),
        .rf_write_is_ref_o  (rf_write_is_ref),
        .rf_write_addr_o    (rf_write_addr),
        .rf_write_data_o    (rf_write_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [63:0] wv(input logic e, input logic r, input logic f,
                                       input logic [4:0] a, input logic [31:0] d);
        return {24'd0, e, r, f, a, d};
    endfunction

    function automatic logic [63:0] obs_wr();
        return {24'd0, rf_write_en, rf_write_restore, rf_write_is_ref, rf_write_addr, rf_write_data};
    endfunction

    // ctl order: rename_ready, commit_ready, flush_done, rf_read_hold
    function automatic logic [63:0] cv4(input logic rr, input logic cr, input logic fd, input logic h);
        return {60'd0, rr, cr, fd, h};
    endfunction

    function automatic logic [63:0] obs_ctl();
        return {60'd0, rename_ready, commit_ready, flush_done, rf_read_hold};
    endfunction

    task automatic cyc(input logic r, input logic fl,
                       input logic rv, input logic [4:0] ra, input logic [4:0] rt,
                       input logic cvl, input logic [4:0] ca, input logic [4:0] ct,
                       input logic [31:0] cd);
        @(negedge clk);
        rst          = r;
        flush_req    = fl;
        rename_valid = rv;
        rename_addr  = ra;
        rename_tag   = rt;
        commit_valid = cvl;
        commit_addr  = ca;
        commit_tag   = ct;
        commit_data  = cd;
        #1;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst = 1; flush_req = 0; rename_valid = 0; rename_addr = 0; rename_tag = 0;
        commit_valid = 0; commit_addr = 0; commit_tag = 0; commit_data = 0;

        // reset: every output low even with requests present
        cyc(1, 0, 1, 5'd3, 5'd1, 1, 5'd3, 5'd1, 32'h5);
        check_eq("reset_wr", obs_wr(), wv(0, 0, 0, 0, 0));
        check_eq("reset_ctl", obs_ctl(), cv4(0, 0, 0, 0));
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        check_eq("post_reset_ctl", obs_ctl(), cv4(1, 1, 0, 0));
        check_eq("post_reset_wr", obs_wr(), wv(0, 0, 0, 0, 0));

        // rename r5/3 then matching commit
        cyc(0, 0, 1, 5'd5, 5'd3, 0, 0, 0, 0);
        check_eq("t1_rename_wr", obs_wr(), wv(1, 0, 1, 5'd5, 32'd3));
        check_eq("t1_rename_rdy", {63'd0, rename_ready}, 64'd1);
        cyc(0, 0, 0, 0, 0, 1, 5'd5, 5'd3, 32'hDEADBEEF);
        check_eq("t1_enq_wr", obs_wr(), wv(0, 0, 0, 0, 0));
        check_eq("t1_enq_rdy", {63'd0, commit_ready}, 64'd1);
        idle();
        check_eq("t1_value_wr", obs_wr(), wv(1, 0, 0, 5'd5, 32'hDEADBEEF));
        check_eq("t1_value_hold", {63'd0, rf_read_hold}, 64'd0);
        // shadow r5 now invalid: foreign tag treated as match
        cyc(0, 0, 0, 0, 0, 1, 5'd5, 5'd9, 32'h22);
        check_eq("t1b_enq_wr", obs_wr(), wv(0, 0, 0, 0, 0));
        idle();
        check_eq("t1b_value_wr", obs_wr(), wv(1, 0, 0, 5'd5, 32'h22));
        check_eq("t1b_value_ctl", obs_ctl(), cv4(1, 1, 0, 0));
        idle();
        check_eq("t1b_no_fixup", obs_wr(), wv(0, 0, 0, 0, 0));

        // stale commit: r7 renamed twice
        cyc(0, 0, 1, 5'd7, 5'd2, 0, 0, 0, 0);
        check_eq("t2_ren1", obs_wr(), wv(1, 0, 1, 5'd7, 32'd2));
        cyc(0, 0, 1, 5'd7, 5'd6, 0, 0, 0, 0);
        check_eq("t2_ren2", obs_wr(), wv(1, 0, 1, 5'd7, 32'd6));
        cyc(0, 0, 0, 0, 0, 1, 5'd7, 5'd2, 32'h11);
        check_eq("t2_enq", obs_wr(), wv(0, 0, 0, 0, 0));
        idle();
        check_eq("t2_stale_wr", obs_wr(), wv(1, 0, 0, 5'd7, 32'h11));
        check_eq("t2_stale_ctl", obs_ctl(), cv4(0, 1, 0, 1));
        cyc(0, 0, 1, 5'd9, 5'd1, 0, 0, 0, 0);
        check_eq("t2_fixup_wr", obs_wr(), wv(1, 0, 1, 5'd7, 32'd6));
        check_eq("t2_fixup_rdy", {63'd0, rename_ready}, 64'd0);
        cyc(0, 0, 1, 5'd9, 5'd1, 0, 0, 0, 0);
        check_eq("t2_after_fixup", obs_wr(), wv(1, 0, 1, 5'd9, 32'd1));
        check_eq("t2_after_rdy", {63'd0, rename_ready}, 64'd1);

        // FIFO fills behind continuous renames
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 1, 5'd20, 5'(10 + i), 1, 5'(11 + i), 5'd0, 32'hA0 + i);
            check_eq($sformatf("t3_ren%0d", i), obs_wr(), wv(1, 0, 1, 5'd20, 32'(10 + i)));
        end
        cyc(0, 0, 1, 5'd20, 5'd14, 0, 0, 0, 0);
        check_eq("t3_full_ctl", obs_ctl(), cv4(0, 0, 0, 0));
        check_eq("t3_full_wr", obs_wr(), wv(1, 0, 0, 5'd11, 32'hA0));
        cyc(0, 0, 1, 5'd20, 5'd14, 0, 0, 0, 0);
        check_eq("t3_ren_again", obs_wr(), wv(1, 0, 1, 5'd20, 32'd14));
        check_eq("t3_ren_again_rdy", {63'd0, rename_ready}, 64'd1);
        for (int i = 1; i < 4; i++) begin
            idle();
            check_eq($sformatf("t3_drain%0d", i), obs_wr(), wv(1, 0, 0, 5'(11 + i), 32'hA0 + i));
        end
        idle();
        check_eq("t3_empty", obs_wr(), wv(0, 0, 0, 0, 0));

        // flush with 3 queued commits, two of them stale
        cyc(0, 0, 1, 5'd21, 5'd1, 1, 5'd20, 5'd3, 32'h100);
        cyc(0, 0, 1, 5'd21, 5'd2, 1, 5'd7, 5'd2, 32'h101);
        cyc(0, 0, 1, 5'd21, 5'd3, 1, 5'd22, 5'd0, 32'h102);
        check_eq("t4_enq_last", obs_wr(), wv(1, 0, 1, 5'd21, 32'd3));
        cyc(0, 1, 1, 5'd21, 5'd9, 0, 0, 0, 0);
        check_eq("t4_flush_ctl", obs_ctl(), cv4(0, 0, 0, 0));
        check_eq("t4_flush_wr", obs_wr(), wv(0, 0, 0, 0, 0));
        cyc(0, 1, 1, 5'd21, 5'd9, 0, 0, 0, 0);
        check_eq("t4_drain0", obs_wr(), wv(1, 0, 0, 5'd20, 32'h100));
        check_eq("t4_drain0_ctl", obs_ctl(), cv4(0, 0, 0, 0));
        cyc(0, 1, 1, 5'd21, 5'd9, 0, 0, 0, 0);
        check_eq("t4_drain1", obs_wr(), wv(1, 0, 0, 5'd7, 32'h101));
        check_eq("t4_drain1_ctl", obs_ctl(), cv4(0, 0, 0, 0));
        cyc(0, 1, 1, 5'd21, 5'd9, 0, 0, 0, 0);
        check_eq("t4_drain2", obs_wr(), wv(1, 0, 0, 5'd22, 32'h102));
        cyc(0, 1, 1, 5'd21, 5'd9, 0, 0, 0, 0);
        check_eq("t4_restore_wr", obs_wr(), wv(0, 1, 0, 0, 0));
        check_eq("t4_restore_ctl", obs_ctl(), cv4(0, 0, 1, 0));
        cyc(0, 0, 1, 5'd21, 5'd9, 0, 0, 0, 0);
        check_eq("t4_resume_wr", obs_wr(), wv(1, 0, 1, 5'd21, 32'd9));
        check_eq("t4_resume_ctl", obs_ctl(), cv4(1, 1, 0, 0));
        // r7 shadow cleared by restore: old tag no longer stale
        cyc(0, 0, 0, 0, 0, 1, 5'd7, 5'd2, 32'h33);
        idle();
        check_eq("t4_r7_value", obs_wr(), wv(1, 0, 0, 5'd7, 32'h33));
        check_eq("t4_r7_hold", {63'd0, rf_read_hold}, 64'd0);
        idle();
        check_eq("t4_r7_no_fixup", obs_wr(), wv(0, 0, 0, 0, 0));

        // r0 never produces a write
        cyc(0, 0, 1, 5'd0, 5'd4, 0, 0, 0, 0);
        check_eq("t5_ren_r0_wr", obs_wr(), wv(0, 0, 0, 0, 0));
        check_eq("t5_ren_r0_rdy", {63'd0, rename_ready}, 64'd1);
        cyc(0, 0, 0, 0, 0, 1, 5'd0, 5'd1, 32'h55);
        check_eq("t5_com_r0_rdy", {63'd0, commit_ready}, 64'd1);
        idle();
        check_eq("t5_head_r0_wr", obs_wr(), wv(0, 0, 0, 0, 0));
        idle();
        check_eq("t5_after_r0_wr", obs_wr(), wv(0, 0, 0, 0, 0));
        check_eq("t5_after_r0_ctl", obs_ctl(), cv4(1, 1, 0, 0));

        // reset in the middle of a drain
        cyc(0, 0, 1, 5'd23, 5'd1, 1, 5'd24, 5'd0, 32'h200);
        cyc(0, 0, 1, 5'd23, 5'd2, 1, 5'd25, 5'd0, 32'h201);
        cyc(0, 0, 1, 5'd23, 5'd3, 1, 5'd26, 5'd0, 32'h202);
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
        check_eq("t6_drain0", obs_wr(), wv(1, 0, 0, 5'd24, 32'h200));
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
        check_eq("t6_rst_wr", obs_wr(), wv(0, 0, 0, 0, 0));
        check_eq("t6_rst_ctl", obs_ctl(), cv4(0, 0, 0, 0));
        idle();
        check_eq("t6_after_wr", obs_wr(), wv(0, 0, 0, 0, 0));
        check_eq("t6_after_ctl", obs_ctl(), cv4(1, 1, 0, 0));
        idle();
        check_eq("t6_fifo_empty", obs_wr(), wv(0, 0, 0, 0, 0));
        check_eq("t6_no_done", {63'd0, flush_done}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rf_write_scheduler.md
Name: rf_write_scheduler

Overview:
Owns the register file's single write channel and shares it between the rename stage (tag writes) and ROB commit (value writes). Keeps a shadow tag table so a commit never clears a newer rename. Sequences flush recovery: drain committed values, then pulse restore. Sits between rename/ROB and the register file; the register file's read channels remain with the rename stage.

Parameters:
COMMIT_FIFO_DEPTH, 4, commit write buffer entries (power of two, >=2)
Widths come from the shared headers: REG_ADDR_BUS (5b), DATA_BUS (32b), ROB_ADDR_BUS (ROB_ADDR_WIDTH).

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
rename_valid  in  1  rename requests dest remap
rename_ready  out  1  rename accepted this cycle when valid&ready
rename_addr  in  REG_ADDR_BUS  architectural dest
rename_tag  in  ROB_ADDR_BUS  new ROB id
commit_valid  in  1  ROB retires a register result
commit_ready  out  1  FIFO can accept
commit_addr  in  REG_ADDR_BUS  dest
commit_tag  in  ROB_ADDR_BUS  retiring ROB id
commit_data  in  DATA_BUS  result value
flush_req  in  1  level, held until flush_done
flush_done  out  1  one-cycle pulse
rf_read_hold  out  1  rename stage must not use register file reads this cycle
rf_write_en, rf_write_restore, rf_write_is_ref  out  1 each  to register file
rf_write_addr  out  REG_ADDR_BUS;  rf_write_data  out  DATA_BUS

Behaviour:
- Reset (rst=1 at clk edge): state NORMAL, FIFO empty, all shadow valid bits 0; all outputs 0 while rst high; rename_ready/commit_ready rise the cycle after rst falls.
- Outputs rf_* are combinational from state/FIFO head/rename inputs (zero-latency rename write); one rf write per cycle max.
- Commit enqueue: commit_valid&commit_ready pushes {addr,tag,data}; commit_ready = !full && state==NORMAL && !flush_req. Writes to r0 are pushed then discarded at head without a write cycle.
- NORMAL, per cycle priority: (1) FIFO full -> process head, rename_ready=0; (2) rename_valid -> rf write {is_ref=1, addr, data=zero-extended tag}, shadow[addr]={1,tag}, rename_ready=1; (3) else FIFO non-empty -> process head.
- Process head, tag match (shadow valid & tag equal): rf write {is_ref=0, data}, clear shadow valid, pop.
- Tag mismatch (stale commit; newer rename outstanding): cycle 1 rf write {is_ref=0,data}, rf_read_hold=1, rename_ready=0, go FIXUP; FIXUP cycle rf write {is_ref=1, data=shadow tag}, pop, rename_ready=0, -> NORMAL. Shadow invalid + not r0: treat as match.
- Same-cycle rename and commit to the same reg: rename writes first; the commit is later handled as stale.
- Flush: flush_req sampled in NORMAL (not FIXUP; FIXUP completes first) -> DRAIN. Commit accepted in the same edge is enqueued before drain. DRAIN: rename_ready=0, commit_ready=0; one FIFO entry per cycle written as value (is_ref=0), no tag check, no fixup. When empty -> RESTORE: rf_write_restore=1, rf_write_en=0, flush_done=1, shadow valid all cleared, -> NORMAL. Empty FIFO on entry: DRAIN lasts 0 cycles (direct to RESTORE).
- FIFO pointers wrap modulo depth; full/empty use extra pointer bit. Push and pop in same cycle when full is permitted only if pop occurs (priority 1 guarantees it).
- rst mid-DRAIN/FIXUP aborts immediately to reset state; no flush_done.

Decomposition:
- Shared header: state encodings (NORMAL, FIXUP, DRAIN, RESTORE), REG_ADDR_BUS/DATA_BUS/ROB_ADDR_BUS widths already in bus.v/rob.v.
- One sub-module: commit_fifo (synchronous FIFO, parameter depth/width, push/pop/full/empty/head).

Test Plan:
- Rename r5 tag 3, then commit r5 tag 3 data 0xDEADBEEF -> cycle 1 write is_ref=1 data 3; later write is_ref=0 data 0xDEADBEEF; shadow r5 invalid.
- Rename r7 tag 2, rename r7 tag 6, commit r7 tag 2 data 0x11 -> value write 0x11 with rf_read_hold=1, next cycle write is_ref=1 data 6, rename_ready=0 both cycles.
- Continuous rename_valid with 4 commits queued (FIFO full) -> rename_ready=0 and head processed each cycle until not full; no commit lost.
- Queue 3 commits, assert flush_req -> 3 value writes in order, then one cycle rf_write_restore=1 with flush_done=1; commit_ready/rename_ready 0 throughout.
- Commit to r0 and rename r0 -> accepted, rf_write_en never asserted with addr 0.
- Assert rst during DRAIN with 2 entries left -> next cycle all outputs 0, FIFO empty, no flush_done.
